// File: rtl/sm4_pkg.sv
// Shared SM4 key-schedule constants, FSM states and the CK / L' helper functions.
package sm4_pkg;

  localparam int SM4_ROUNDS = 32;

  localparam logic [31:0] FK0 = 32'hA3B1BAC6;
  localparam logic [31:0] FK1 = 32'h56AA3350;
  localparam logic [31:0] FK2 = 32'h677D9197;
  localparam logic [31:0] FK3 = 32'hB27022DC;

  typedef enum logic {IDLE, RUN} state_t;

  // CK byte j of round r is (4r+j)*7 mod 256, byte 0 in the MSB position.
  function automatic logic [31:0] ck(input logic [4:0] round);
    logic [31:0] w;
    logic [7:0]  b;
    w = '0;
    for (int j = 0; j < 4; j++) begin
      b = {1'b0, round, 2'b00} + 8'(j);
      b = b * 8'd7;
      w[31-8*j -: 8] = b;
    end
    return w;
  endfunction

  function automatic logic [31:0] l_prime(input logic [31:0] b);
    return b ^ {b[18:0], b[31:19]} ^ {b[8:0], b[31:9]};
  endfunction

endpackage

// File: rtl/sm4_key_round.sv
// One combinational key-schedule round: rk = K0 ^ L'(tau(K1^K2^K3^CK)).
module sm4_key_round
  import sm4_pkg::*;
(
  input  logic [31:0] k0,
  input  logic [31:0] k1,
  input  logic [31:0] k2,
  input  logic [31:0] k3,
  input  logic [31:0] ck_word,
  output logic [31:0] rk
);

  logic [31:0] t;
  logic [31:0] b;

  assign t = k1 ^ k2 ^ k3 ^ ck_word;

  t_change u_tau (.din(t), .dout(b));

  assign rk = k0 ^ l_prime(b);

endmodule

// File: rtl/t_change.sv
// SM4 tau: four parallel byte S-boxes over a 32-bit word.
module sm4_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);

  localparam logic [0:255][7:0] SBOX = {
    8'hd6, 8'h90, 8'he9, 8'hfe, 8'hcc, 8'he1, 8'h3d, 8'hb7, 8'h16, 8'hb6, 8'h14, 8'hc2, 8'h28, 8'hfb, 8'h2c, 8'h05,
    8'h2b, 8'h67, 8'h9a, 8'h76, 8'h2a, 8'hbe, 8'h04, 8'hc3, 8'haa, 8'h44, 8'h13, 8'h26, 8'h49, 8'h86, 8'h06, 8'h99,
    8'h9c, 8'h42, 8'h50, 8'hf4, 8'h91, 8'hef, 8'h98, 8'h7a, 8'h33, 8'h54, 8'h0b, 8'h43, 8'hed, 8'hcf, 8'hac, 8'h62,
    8'he4, 8'hb3, 8'h1c, 8'ha9, 8'hc9, 8'h08, 8'he8, 8'h95, 8'h80, 8'hdf, 8'h94, 8'hfa, 8'h75, 8'h8f, 8'h3f, 8'ha6,
    8'h47, 8'h07, 8'ha7, 8'hfc, 8'hf3, 8'h73, 8'h17, 8'hba, 8'h83, 8'h59, 8'h3c, 8'h19, 8'he6, 8'h85, 8'h4f, 8'ha8,
    8'h68, 8'h6b, 8'h81, 8'hb2, 8'h71, 8'h64, 8'hda, 8'h8b, 8'hf8, 8'heb, 8'h0f, 8'h4b, 8'h70, 8'h56, 8'h9d, 8'h35,
    8'h1e, 8'h24, 8'h0e, 8'h5e, 8'h63, 8'h58, 8'hd1, 8'ha2, 8'h25, 8'h22, 8'h7c, 8'h3b, 8'h01, 8'h21, 8'h78, 8'h87,
    8'hd4, 8'h00, 8'h46, 8'h57, 8'h9f, 8'hd3, 8'h27, 8'h52, 8'h4c, 8'h36, 8'h02, 8'he7, 8'ha0, 8'hc4, 8'hc8, 8'h9e,
    8'hea, 8'hbf, 8'h8a, 8'hd2, 8'h40, 8'hc7, 8'h38, 8'hb5, 8'ha3, 8'hf7, 8'hf2, 8'hce, 8'hf9, 8'h61, 8'h15, 8'ha1,
    8'he0, 8'hae, 8'h5d, 8'ha4, 8'h9b, 8'h34, 8'h1a, 8'h55, 8'had, 8'h93, 8'h32, 8'h30, 8'hf5, 8'h8c, 8'hb1, 8'he3,
    8'h1d, 8'hf6, 8'he2, 8'h2e, 8'h82, 8'h66, 8'hca, 8'h60, 8'hc0, 8'h29, 8'h23, 8'hab, 8'h0d, 8'h53, 8'h4e, 8'h6f,
    8'hd5, 8'hdb, 8'h37, 8'h45, 8'hde, 8'hfd, 8'h8e, 8'h2f, 8'h03, 8'hff, 8'h6a, 8'h72, 8'h6d, 8'h6c, 8'h5b, 8'h51,
    8'h8d, 8'h1b, 8'haf, 8'h92, 8'hbb, 8'hdd, 8'hbc, 8'h7f, 8'h11, 8'hd9, 8'h5c, 8'h41, 8'h1f, 8'h10, 8'h5a, 8'hd8,
    8'h0a, 8'hc1, 8'h31, 8'h88, 8'ha5, 8'hcd, 8'h7b, 8'hbd, 8'h2d, 8'h74, 8'hd0, 8'h12, 8'hb8, 8'he5, 8'hb4, 8'hb0,
    8'h89, 8'h69, 8'h97, 8'h4a, 8'h0c, 8'h96, 8'h77, 8'h7e, 8'h65, 8'hb9, 8'hf1, 8'h09, 8'hc5, 8'h6e, 8'hc6, 8'h84,
    8'h18, 8'hf0, 8'h7d, 8'hec, 8'h3a, 8'hdc, 8'h4d, 8'h20, 8'h79, 8'hee, 8'h5f, 8'h3e, 8'hd7, 8'hcb, 8'h39, 8'h48
  };

  assign y = SBOX[a];

endmodule

module t_change (
  input  logic [31:0] din,
  output logic [31:0] dout
);

  for (genvar g = 0; g < 4; g++) begin : g_lane
    sm4_sbox u_sbox (.a(din[8*g +: 8]), .y(dout[8*g +: 8]));
  end

endmodule

// File: rtl/sm4_key_expand.sv
// Iterative SM4 key expansion: one round key per clock, streamed and buffered.
module sm4_key_expand
  import sm4_pkg::*;
#(
  parameter int ROUNDS = SM4_ROUNDS
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         key_start,
  input  logic [127:0] key_in,
  output logic         busy,
  output logic         rk_valid,
  output logic [4:0]   rk_index,
  output logic [31:0]  rk_out,
  output logic         done,
  output logic         keys_valid,
  input  logic [4:0]   rd_addr,
  input  logic         rd_dec,
  output logic [31:0]  rd_data
);

  state_t      state, state_nxt;
  logic [4:0]  round;
  logic [31:0] k [4];
  logic [31:0] mem [ROUNDS];
  logic [31:0] rk;
  logic        accept;
  logic        last;

  assign accept = (state == IDLE) && key_start;
  assign last   = (round == 5'(ROUNDS - 1));
  assign busy   = (state == RUN);

  sm4_key_round u_round (
    .k0(k[0]), .k1(k[1]), .k2(k[2]), .k3(k[3]),
    .ck_word(ck(round)),
    .rk(rk)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (key_start) state_nxt = RUN;
      RUN:     if (last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      round      <= '0;
      rk_valid   <= 1'b0;
      rk_index   <= '0;
      rk_out     <= '0;
      done       <= 1'b0;
      keys_valid <= 1'b0;
    end else begin
      state    <= state_nxt;
      rk_valid <= 1'b0;
      done     <= 1'b0;
      if (accept) begin
        round      <= '0;
        keys_valid <= 1'b0;
      end else if (busy) begin
        round    <= round + 5'd1;
        rk_valid <= 1'b1;
        rk_index <= round;
        rk_out   <= rk;
        done     <= last;
        if (last) keys_valid <= 1'b1;
      end
    end
  end

  // Key state and buffer carry no reset; keys_valid marks their usability.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (accept) begin
        k[0] <= key_in[127:96] ^ FK0;
        k[1] <= key_in[95:64]  ^ FK1;
        k[2] <= key_in[63:32]  ^ FK2;
        k[3] <= key_in[31:0]   ^ FK3;
      end else if (busy) begin
        k[0]       <= k[1];
        k[1]       <= k[2];
        k[2]       <= k[3];
        k[3]       <= rk;
        mem[round] <= rk;
      end
    end
  end

  // 31-addr is the bitwise complement for a 5-bit index.
  always_ff @(posedge clk) begin
    if (rst) rd_data <= '0;
    else     rd_data <= mem[rd_dec ? ~rd_addr : rd_addr];
  end

endmodule
